// File: rtl/mem_responder_if.sv
// mem_responder_if: sys req/wr/rdy memory bus between one initiator and the responder
//   req/wr/addr/wdata : initiator -> responder request
//   rdata/rdy/err     : responder -> initiator completion
interface mem_responder_if;
  logic        req;
  logic        wr;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [63:0] rdata;
  logic        rdy;
  logic        err;
  modport master (output req, wr, addr, wdata, input rdata, rdy, err);
  modport slave  (input req, wr, addr, wdata, output rdata, rdy, err);
endinterface

// File: rtl/mem_responder.sv
// mem_responder: fixed-latency single-outstanding responder backed by a 64-bit RAM
//   clk    : sole clock, rising edge
//   rst    : asynchronous active-low reset
//   sys    : slave side of the req/wr/rdy bus (rdata registered, rdy/err one-cycle pulses)
//   rd_cnt : completed reads, wraps
//   wr_cnt : completed writes including out-of-range drops, wraps
module mem_responder #(
  parameter int DEPTH  = 8192,
  parameter int AW     = 13,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave sys,
  output logic [31:0]    rd_cnt,
  output logic [31:0]    wr_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rdata_q, rdata_d;
  logic        rdy_q, rdy_d;
  logic        err_q, err_d;
  logic [31:0] rd_cnt_q, rd_cnt_d;
  logic [31:0] wr_cnt_q, wr_cnt_d;
  logic [63:0] mem [DEPTH];
  logic [AW-1:0] idx;
  logic        oor;
  logic        commit;
  assign idx    = addr_q[AW-1:0];
  // DEPTH is 2**AW, so any set bit above the index field is out of range
  assign oor    = |(addr_q >> AW);
  assign commit = state_q == BUSY && cnt_q == '0;
  assign sys.rdata = rdata_q;
  assign sys.rdy   = rdy_q;
  assign sys.err   = err_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    rdy_d    = 1'b0;
    err_d    = 1'b0;
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    case (state_q)
      // GAP is the one dead cycle after RESP; the edge that closes it may already
      // capture, giving one transaction every LAT+2 cycles
      IDLE, GAP: begin
        state_d = sys.req ? BUSY : IDLE;
        if (sys.req) begin
          wr_d    = sys.wr;
          addr_d  = sys.addr;
          wdata_d = sys.wdata;
          cnt_d   = sys.wr ? 8'(WR_LAT - 1) : 8'(RD_LAT - 1);
        end
      end
      BUSY: begin
        state_d  = commit ? RESP : BUSY;
        cnt_d    = commit ? cnt_q : cnt_q - 8'd1;
        rdy_d    = commit;
        err_d    = commit && oor;
        rdata_d  = commit && !wr_q ? (oor ? '0 : mem[idx]) : rdata_q;
        rd_cnt_d = rd_cnt_q + 32'(commit && !wr_q);
        wr_cnt_d = wr_cnt_q + 32'(commit && wr_q);
      end
      RESP:    state_d = GAP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rdy_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      rdy_q    <= rdy_d;
      err_q    <= err_d;
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end
  // RAM has no reset; a reset that lands before the commit edge leaves state_q
  // out of BUSY, so the aborted write never reaches the array
  always_ff @(posedge clk)
    if (commit && wr_q && !oor) mem[idx] <= wdata_q;
endmodule
